// File: rtl/radar_trigger_generator.sv
// Pulse-repetition trigger generator: bursts of N single-cycle triggers (or a continuous train) at a fixed PRI.
// Optional macro TRIGGER_STAGGER_EN adds ipPeriodB and alternates PRI A/B between triggers.
module radar_trigger_generator #(
    parameter int unsigned PRI_WIDTH   = 24,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic                   ipEnable,
    input  logic                   ipStart,
    input  logic [PRI_WIDTH-1:0]   ipPeriod,
`ifdef TRIGGER_STAGGER_EN
    input  logic [PRI_WIDTH-1:0]   ipPeriodB,
`endif
    input  logic [COUNT_WIDTH-1:0] ipBurstLength,
    output logic                   opMasterTrigger,
    output logic                   opBusy,
    output logic                   opDone,
    output logic [COUNT_WIDTH-1:0] opTriggerCount
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_n;
    logic [PRI_WIDTH-1:0]   interval_cnt, interval_cnt_n;
    logic [PRI_WIDTH-1:0]   reload_a, reload_a_n;
    logic [COUNT_WIDTH-1:0] burst_len, burst_len_n;
    logic                   trigger_n, busy_n, done_n;
    logic [COUNT_WIDTH-1:0] trig_count_n;
    logic [PRI_WIDTH-1:0]   reload_val_c;
`ifdef TRIGGER_STAGGER_EN
    logic [PRI_WIDTH-1:0]   reload_b, reload_b_n;
    logic                   use_b, use_b_n;
`endif

    // Interval counter reload value is PRI-1 so expiry lands exactly one PRI after a trigger.
    function automatic logic [PRI_WIDTH-1:0] pri_reload(input logic [PRI_WIDTH-1:0] p);
        return (p < PRI_WIDTH'(2)) ? PRI_WIDTH'(1) : (p - PRI_WIDTH'(1));
    endfunction

`ifdef TRIGGER_STAGGER_EN
    assign reload_val_c = use_b ? reload_b : reload_a;
`else
    assign reload_val_c = reload_a;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        interval_cnt_n = interval_cnt;
        reload_a_n     = reload_a;
        burst_len_n    = burst_len;
        trigger_n      = 1'b0;
        done_n         = 1'b0;
        busy_n         = opBusy;
        trig_count_n   = opTriggerCount;
`ifdef TRIGGER_STAGGER_EN
        reload_b_n     = reload_b;
        use_b_n        = use_b;
`endif
        case (state)
            IDLE: begin
                if (ipStart && ipEnable) begin
                    state_n        = RUN;
                    reload_a_n     = pri_reload(ipPeriod);
                    burst_len_n    = ipBurstLength;
                    interval_cnt_n = pri_reload(ipPeriod);
                    trigger_n      = 1'b1;
                    busy_n         = 1'b1;
                    trig_count_n   = COUNT_WIDTH'(1);
`ifdef TRIGGER_STAGGER_EN
                    reload_b_n     = pri_reload(ipPeriodB);
                    use_b_n        = 1'b1;
`endif
                end
            end
            RUN: begin
                if (!ipEnable) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (interval_cnt == '0) begin
                    if ((burst_len != '0) && (opTriggerCount == burst_len)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        trigger_n      = 1'b1;
                        trig_count_n   = opTriggerCount + COUNT_WIDTH'(1);
                        interval_cnt_n = reload_val_c;
`ifdef TRIGGER_STAGGER_EN
                        use_b_n        = ~use_b;
`endif
                    end
                end else begin
                    interval_cnt_n = interval_cnt - PRI_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state           <= IDLE;
            interval_cnt    <= '0;
            reload_a        <= '0;
            burst_len       <= '0;
            opMasterTrigger <= 1'b0;
            opBusy          <= 1'b0;
            opDone          <= 1'b0;
            opTriggerCount  <= '0;
`ifdef TRIGGER_STAGGER_EN
            reload_b        <= '0;
            use_b           <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            interval_cnt    <= interval_cnt_n;
            reload_a        <= reload_a_n;
            burst_len       <= burst_len_n;
            opMasterTrigger <= trigger_n;
            opBusy          <= busy_n;
            opDone          <= done_n;
            opTriggerCount  <= trig_count_n;
`ifdef TRIGGER_STAGGER_EN
            reload_b        <= reload_b_n;
            use_b           <= use_b_n;
`endif
        end
    end

endmodule
